// File: rtl/traffic_light_monitor_if.sv
// Light sample and monitor result bundle between a light controller (master)
// and the traffic light monitor (slave).
interface traffic_light_monitor_if;
    logic [2:0] n_lights;
    logic [2:0] s_lights;
    logic [2:0] e_lights;
    logic [2:0] w_lights;
    logic       clr_err;
    logic [2:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       illegal_err;
    logic       seq_err;
    logic       dwell_err;
    logic       cycle_done;
    logic [2:0] err_status;
    logic [7:0] err_cnt;

    modport master (
        output n_lights, s_lights, e_lights, w_lights, clr_err,
        input  phase, phase_valid, locked, illegal_err, seq_err, dwell_err,
               cycle_done, err_status, err_cnt
    );

    modport slave (
        input  n_lights, s_lights, e_lights, w_lights, clr_err,
        output phase, phase_valid, locked, illegal_err, seq_err, dwell_err,
               cycle_done, err_status, err_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Watches a four-way traffic light and flags illegal patterns, out-of-order
// phases and wrong dwell times; reports clean full rotations.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_a,
    traffic_light_monitor_if.slave bus
);

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam logic [4:0] GREEN_DW  = 5'(GREEN_CYCLES);
    localparam logic [4:0] YELLOW_DW = 5'(YELLOW_CYCLES);
    localparam logic [4:0] STUCK_DW  = 5'(2 * GREEN_CYCLES);
    localparam logic [4:0] DWELL_MAX = 5'd31;

    // Returns {legal, phase}; phase is direction*2 plus one for yellow.
    function automatic logic [3:0] decode_sample(input logic [2:0] n, input logic [2:0] s,
                                                 input logic [2:0] e, input logic [2:0] w);
        logic [3:0] red;
        logic [2:0] code;
        logic [1:0] dir;
        logic       hit;
        red  = {w == 3'b100, e == 3'b100, s == 3'b100, n == 3'b100};
        hit  = 1'b1;
        dir  = 2'd0;
        code = n;
        case (red)
            4'b1110: begin dir = 2'd0; code = n; end
            4'b1101: begin dir = 2'd1; code = s; end
            4'b1011: begin dir = 2'd2; code = e; end
            4'b0111: begin dir = 2'd3; code = w; end
            default: hit = 1'b0;
        endcase
        if (code == 3'b001) begin
            return {hit, dir, 1'b0};
        end else if (code == 3'b010) begin
            return {hit, dir, 1'b1};
        end else begin
            return {1'b0, dir, 1'b0};
        end
    endfunction

    state_e     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic       phase_valid_q, phase_valid_d;
    logic       locked_q, locked_d;
    logic       illegal_q, illegal_d;
    logic       seq_q, seq_d;
    logic       dwell_err_q, dwell_err_d;
    logic       cycle_done_q, cycle_done_d;
    logic [2:0] err_status_q, err_status_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [4:0] dwell_q, dwell_d;
    logic       checked_q, checked_d;
    logic       clean_q, clean_d;

    logic [3:0] dec_s;
    logic       legal_s;
    logic [2:0] sample_phase_s;
    logic [4:0] dwell_need_s;
    logic       any_err_s;

    // Next-state, phase tracking and error generation.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        dwell_d        = dwell_q;
        checked_d      = checked_q;
        clean_d        = clean_q;
        illegal_d      = 1'b0;
        seq_d          = 1'b0;
        dwell_err_d    = 1'b0;
        cycle_done_d   = 1'b0;
        dec_s          = decode_sample(bus.n_lights, bus.s_lights, bus.e_lights, bus.w_lights);
        legal_s        = dec_s[3];
        sample_phase_s = dec_s[2:0];
        phase_valid_d  = legal_s;
        dwell_need_s   = phase_q[0] ? YELLOW_DW : GREEN_DW;

        if (!legal_s) begin
            illegal_d = 1'b1;
            state_d   = SYNC;
            dwell_d   = 5'd0;
            checked_d = 1'b0;
        end else begin
            phase_d = sample_phase_s;
            case (state_q)
                SYNC: begin
                    state_d   = TRACK;
                    dwell_d   = 5'd1;
                    checked_d = 1'b0;
                end
                TRACK: begin
                    if (sample_phase_s == phase_q) begin
                        // Saturation keeps the stuck-light pulse from ever recurring.
                        if (dwell_q != DWELL_MAX) begin
                            dwell_d = dwell_q + 5'd1;
                        end else begin
                            dwell_d = dwell_q;
                        end
                        if (dwell_q != DWELL_MAX && (dwell_q + 5'd1) == STUCK_DW) begin
                            dwell_err_d = 1'b1;
                        end else begin
                            dwell_err_d = 1'b0;
                        end
                    end else if (sample_phase_s == phase_q + 3'd1) begin
                        dwell_d   = 5'd1;
                        checked_d = 1'b1;
                        if (!checked_q) begin
                            dwell_err_d = 1'b0;
                        end else if (dwell_q != dwell_need_s) begin
                            dwell_err_d = 1'b1;
                        end else begin
                            if (phase_q == 3'd0) begin
                                clean_d = 1'b1;
                            end else begin
                                clean_d = clean_q;
                            end
                            if (phase_q == 3'd7 && clean_q) begin
                                cycle_done_d = 1'b1;
                            end else begin
                                cycle_done_d = 1'b0;
                            end
                        end
                    end else begin
                        seq_d     = 1'b1;
                        dwell_d   = 5'd1;
                        checked_d = 1'b0;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end

        any_err_s = illegal_d | seq_d | dwell_err_d;
        if (any_err_s || state_d == SYNC || state_q == SYNC) begin
            clean_d = 1'b0;
        end else begin
            clean_d = clean_d;
        end

        // A same-cycle error survives clr_err.
        if (bus.clr_err) begin
            err_status_d = {dwell_err_d, seq_d, illegal_d};
        end else begin
            err_status_d = err_status_q | {dwell_err_d, seq_d, illegal_d};
        end

        if (any_err_s && err_cnt_q != 8'd255) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        locked_d = (state_d == TRACK);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q       <= SYNC;
            phase_q       <= 3'd0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            illegal_q     <= 1'b0;
            seq_q         <= 1'b0;
            dwell_err_q   <= 1'b0;
            cycle_done_q  <= 1'b0;
            err_status_q  <= 3'd0;
            err_cnt_q     <= 8'd0;
            dwell_q       <= 5'd0;
            checked_q     <= 1'b0;
            clean_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            illegal_q     <= illegal_d;
            seq_q         <= seq_d;
            dwell_err_q   <= dwell_err_d;
            cycle_done_q  <= cycle_done_d;
            err_status_q  <= err_status_d;
            err_cnt_q     <= err_cnt_d;
            dwell_q       <= dwell_d;
            checked_q     <= checked_d;
            clean_q       <= clean_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = locked_q;
    assign bus.illegal_err = illegal_q;
    assign bus.seq_err     = seq_q;
    assign bus.dwell_err   = dwell_err_q;
    assign bus.cycle_done  = cycle_done_q;
    assign bus.err_status  = err_status_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a run-length reference model
// predicts each registered response, a monitor compares one cycle later.
module tb_traffic_light_monitor;

    localparam int GREEN  = 8;
    localparam int YELLOW = 4;

    typedef struct packed {
        logic [2:0] phase;
        logic       pv;
        logic       locked;
        logic       ill;
        logic       seq;
        logic       dw;
        logic       done;
        logic [2:0] status;
        logic [7:0] cnt;
    } obs_t;

    logic clk;
    logic rst_a;
    traffic_light_monitor_if bus ();

    traffic_light_monitor #(.GREEN_CYCLES(GREEN), .YELLOW_CYCLES(YELLOW)) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    // reference model state: run length of the current phase, count of
    // consecutive good checked phase changes
    int         m_track, m_phase, m_run, m_step, m_good, m_cnt;
    logic [2:0] m_status;

    function automatic obs_t obs_now();
        obs_t o;
        o.phase  = bus.phase;
        o.pv     = bus.phase_valid;
        o.locked = bus.locked;
        o.ill    = bus.illegal_err;
        o.seq    = bus.seq_err;
        o.dw     = bus.dwell_err;
        o.done   = bus.cycle_done;
        o.status = bus.err_status;
        o.cnt    = bus.err_cnt;
        return o;
    endfunction

    task automatic model_reset();
        m_track = 0; m_phase = 0; m_run = 0; m_step = 0; m_good = 0; m_cnt = 0;
        m_status = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                              input logic [2:0] w, input logic clr, output obs_t ex);
        logic [2:0] cs[4];
        logic [2:0] code;
        int reds, dir, p, need, run_sat;
        logic ill, sq, dw, dn;
        cs[0] = n; cs[1] = s; cs[2] = e; cs[3] = w;
        reds = 0; dir = 0; code = 3'b000;
        ill = 1'b0; sq = 1'b0; dw = 1'b0; dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cs[i] == 3'b100) reds++;
            else begin dir = i; code = cs[i]; end
        end
        if (reds != 3 || !(code == 3'b001 || code == 3'b010)) begin
            ill = 1'b1;
            m_track = 0;
        end else begin
            p = dir * 2 + ((code == 3'b010) ? 1 : 0);
            if (m_track == 0) begin
                m_track = 1; m_phase = p; m_run = 1; m_step = 0; m_good = 0;
            end else if (p == m_phase) begin
                m_run++;
                if (m_run == 2 * GREEN) dw = 1'b1;
            end else if (p == (m_phase + 1) % 8) begin
                if (m_step != 0) begin
                    need = (m_phase % 2 == 0) ? GREEN : YELLOW;
                    run_sat = (m_run > 31) ? 31 : m_run;
                    if (run_sat != need) dw = 1'b1;
                    else begin
                        m_good++;
                        if (p == 0 && m_good >= 8) dn = 1'b1;
                    end
                end
                m_phase = p; m_run = 1; m_step = 1;
            end else begin
                sq = 1'b1; m_phase = p; m_run = 1; m_step = 0;
            end
        end
        if (ill || sq || dw) m_good = 0;
        if (clr) m_status = 3'b000;
        m_status = m_status | {dw, sq, ill};
        if ((ill || sq || dw) && m_cnt < 255) m_cnt++;
        ex.phase  = 3'(m_phase);
        ex.pv     = ~ill;
        ex.locked = (m_track != 0);
        ex.ill    = ill;
        ex.seq    = sq;
        ex.dw     = dw;
        ex.done   = dn;
        ex.status = m_status;
        ex.cnt    = 8'(m_cnt);
    endtask

    task automatic step(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                        input logic [2:0] w, input logic clr);
        obs_t ex;
        @(negedge clk);
        bus.n_lights = n; bus.s_lights = s; bus.e_lights = e; bus.w_lights = w;
        bus.clr_err  = clr;
        model_step(n, s, e, w, clr, ex);
        sb_q.push_back(ex);
    endtask

    task automatic drive_phase(input int p, input int len, input bit rclr);
        logic [2:0] c[4];
        logic clr;
        for (int i = 0; i < 4; i++) c[i] = 3'b100;
        c[p / 2] = (p % 2 == 1) ? 3'b010 : 3'b001;
        for (int k = 0; k < len; k++) begin
            clr = rclr ? ($urandom_range(0, 19) == 0) : 1'b0;
            step(c[0], c[1], c[2], c[3], clr);
        end
    endtask

    task automatic rotation();
        for (int p = 0; p < 8; p++) drive_phase(p, (p % 2 == 0) ? GREEN : YELLOW, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    // Scoreboard monitor: one registered response per issued sample.
    always @(posedge clk) begin
        obs_t got, ex;
        #1;
        if (sb_q.size() > 0) begin
            ex  = sb_q.pop_front();
            got = obs_now();
            total++;
            if (got.done) done_seen++;
            if (got !== ex) begin
                bad++;
                $display("FAIL outputs @%0t: got ph=%0d pv=%b lk=%b ill=%b seq=%b dw=%b done=%b st=%b cnt=%0d need ph=%0d pv=%b lk=%b ill=%b seq=%b dw=%b done=%b st=%b cnt=%0d",
                         $time, got.phase, got.pv, got.locked, got.ill, got.seq, got.dw, got.done,
                         got.status, got.cnt, ex.phase, ex.pv, ex.locked, ex.ill, ex.seq, ex.dw,
                         ex.done, ex.status, ex.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, r, len;
        rst_a = 1'b1;
        bus.n_lights = 3'b100; bus.s_lights = 3'b100;
        bus.e_lights = 3'b100; bus.w_lights = 3'b100;
        bus.clr_err  = 1'b0;
        model_reset();
        #2;
        chk("reset_outputs", int'(obs_now()), 0);
        @(posedge clk);
        #1 rst_a = 1'b0;

        // nominal rotation twice, back into N (held 9 for the next case)
        rotation();
        rotation();
        drive_phase(0, 9, 1'b0);
        settle();
        chk("nominal_cycle_done", done_seen, 1);
        chk("nominal_err_cnt", int'(bus.err_cnt), 0);
        chk("nominal_locked", int'(bus.locked), 1);

        // N held 9: dwell error on entering N_Y, no cycle_done afterwards
        for (int q = 1; q < 8; q++) drive_phase(q, (q % 2 == 0) ? GREEN : YELLOW, 1'b0);
        drive_phase(0, 1, 1'b0);
        settle();
        chk("long_green_status", int'(bus.err_status), 4);
        chk("long_green_cnt", int'(bus.err_cnt), 1);
        chk("long_green_no_done", done_seen, 1);

        // S_Y jumps straight to W
        drive_phase(0, 7, 1'b0);
        drive_phase(1, 4, 1'b0);
        drive_phase(2, 8, 1'b0);
        drive_phase(3, 4, 1'b0);
        drive_phase(6, 1, 1'b0);
        settle();
        chk("seq_pulse", int'(bus.seq_err), 1);
        chk("seq_phase", int'(bus.phase), 6);
        chk("seq_locked", int'(bus.locked), 1);
        drive_phase(6, 2, 1'b0);

        // two greens at once, then resume
        step(3'b001, 3'b100, 3'b001, 3'b100, 1'b0);
        settle();
        chk("illegal_pulse", int'(bus.illegal_err), 1);
        chk("illegal_pv", int'(bus.phase_valid), 0);
        chk("illegal_unlocked", int'(bus.locked), 0);
        drive_phase(6, 5, 1'b0);
        drive_phase(7, 4, 1'b0);

        // stuck green, then clear together with a new error
        drive_phase(0, 16, 1'b0);
        drive_phase(1, 1, 1'b0);
        step(3'b100, 3'b100, 3'b100, 3'b100, 1'b1);
        settle();
        chk("clr_with_err_status", int'(bus.err_status), 1);

        // randomized runs of phases, jumps and garbage codes
        p = 1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            end else begin
                if (r < 20) p = $urandom_range(0, 7);
                else p = (p + 1) % 8;
                len = (p % 2 == 0) ? GREEN : YELLOW;
                if ($urandom_range(0, 9) == 0) len = len + $urandom_range(0, 2) - 1;
                drive_phase(p, len, 1'b1);
            end
        end

        // saturate the error counter
        for (int k = 0; k < 300; k++) step(3'b100, 3'b100, 3'b100, 3'b100, 1'b0);
        settle();
        chk("err_cnt_saturated", int'(bus.err_cnt), 255);

        // asynchronous reset between clock edges
        #1 rst_a = 1'b1;
        #1;
        chk("async_reset_outputs", int'(obs_now()), 0);
        model_reset();
        @(posedge clk);
        #1 rst_a = 1'b0;

        // after reset, the first legal phase is unchecked
        drive_phase(3, 2, 1'b0);
        drive_phase(4, 8, 1'b0);
        drive_phase(5, 4, 1'b0);
        drive_phase(6, 1, 1'b0);
        settle();
        chk("post_reset_err_cnt", int'(bus.err_cnt), 0);
        chk("post_reset_locked", int'(bus.locked), 1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter GREEN_CYCLES, default 8: required dwell, in clk cycles, of each green phase.
REQ-002 Parameter YELLOW_CYCLES, default 4: required dwell, in clk cycles, of each yellow phase.
REQ-003 clk  input  1  sampling clock, the same slow clock that drives the light controller; all logic SHALL be rising-edge triggered.
REQ-004 rst_a  input  1  reset, asynchronous, active-high.
REQ-005 n_lights, s_lights, e_lights, w_lights  input  3 each  light codes: 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-006 clr_err  input  1  synchronous clear of err_status.
REQ-007 phase  output  3  decoded phase: N=0, N_Y=1, S=2, S_Y=3, E=4, E_Y=5, W=6, W_Y=7.
REQ-008 phase_valid  output  1  the light sample in the previous cycle was a legal pattern.
REQ-009 locked  output  1  the FSM is in TRACK.
REQ-010 illegal_err, seq_err, dwell_err  output  1 each  single-cycle error pulses.
REQ-011 cycle_done  output  1  single-cycle pulse marking a clean full rotation.
REQ-012 err_status  output  3  sticky error flags {dwell, seq, illegal}.
REQ-013 err_cnt  output  8  saturating error counter.

Function
REQ-014 All outputs SHALL be registered, with latency of 1 clk from input sample to output.
REQ-015 A sample SHALL be legal iff exactly one direction is 001 or 010 and the other three are 100; that direction and its colour select phase.
REQ-016 Every other sample (all-red, two non-red, any non-one-hot code) SHALL produce: illegal_err=1 for 1 cycle, phase_valid=0, phase held, and FSM -> SYNC.
REQ-017 FSM states SHALL be SYNC and TRACK.
REQ-018 SYNC SHALL be entered on reset.
REQ-019 In SYNC, the first legal sample SHALL go to TRACK with dwell counter=1; that partial phase SHALL NOT be dwell-checked.
REQ-020 In TRACK, a legal sample equal to the current phase SHALL increment the 5-bit dwell counter, saturating at 31.
REQ-021 In TRACK, a legal sample equal to (phase+1) mod 8 SHALL compare the dwell counter against GREEN_CYCLES (even phase) or YELLOW_CYCLES (odd phase).
REQ-022 A mismatch under REQ-021 SHALL pulse dwell_err; dwell counter -> 1 and FSM stays in TRACK.
REQ-023 In TRACK, while the phase is unchanged, dwell counter reaching 2*GREEN_CYCLES SHALL pulse dwell_err once (stuck light), not repeat until the phase changes, and FSM stays in TRACK.
REQ-024 In TRACK, a legal sample equal to neither phase nor phase+1 SHALL pulse seq_err, set dwell counter=1, and leave the new phase unchecked (as in REQ-019), staying in TRACK.
REQ-025 A clean flag SHALL be set on the N->... transition out of a checked phase and cleared by any error or by entry to SYNC.
REQ-026 cycle_done SHALL pulse on the W_Y->N transition iff all 8 phases since the previous N entry were dwell-checked without error.
REQ-027 err_status bits SHALL set on their corresponding pulse and clear when clr_err=1; set SHALL win when both occur in the same cycle.
REQ-028 err_cnt SHALL increment by exactly 1 in any cycle with at least one error pulse and SHALL saturate at 255; clr_err SHALL NOT affect err_cnt.
REQ-029 Error pulses SHALL be mutually exclusive per cycle in priority illegal > seq > dwell.

Reset
REQ-030 On rst_a=1, asynchronously: phase=0, phase_valid=0, locked=0, all pulses=0, err_status=0, err_cnt=0, dwell counter=0, clean=0, FSM=SYNC.
REQ-031 Reset asserted mid-rotation SHALL discard all tracking; after release, the first legal sample SHALL be treated per REQ-019.

Verification
REQ-032 Reset, then drive the nominal rotation N(8)/N_Y(4)/S(8)/S_Y(4)/E(8)/E_Y(4)/W(8)/W_Y(4) twice -> no errors, locked=1, one cycle_done per W_Y->N after the first full checked rotation, err_cnt=0.
REQ-033 Hold N green for 9 cycles, then N_Y -> dwell_err pulse 1 cycle after the first N_Y sample, err_status=3'b100, err_cnt=1, no cycle_done at the next W_Y->N.
REQ-034 From S_Y, jump to W -> seq_err pulse, err_status[1]=1, locked stays 1, phase=6.
REQ-035 Drive n_lights=001 and e_lights=001 for 1 cycle -> illegal_err, phase_valid=0, locked=0; resume legal phase -> relock with no dwell check.
REQ-036 Hold N green for 16 cycles -> single dwell_err at dwell 16; then assert clr_err together with a new error -> err_status remains set.
REQ-037 Force 300 error cycles -> err_cnt=255; assert rst_a asynchronously mid-cycle -> all outputs per REQ-030 before the next clk edge.
